// File: rtl/dom_rand_gen.sv
// Seeded LFSR unrolled ZW steps per advance feeding the DOM gadget Z bus; outputs registered, first word WARMUP_CYC+1 cycles after the last seed beat.
// Valid/ready output: a stalled consumer freezes ZxDO and the LFSR; seed beats are accepted only while SeedReadyxSO is high.
module dom_rand_gen #(
    parameter int SHARES     = 4,
    parameter int LFSR_W     = 64,
    parameter int WARMUP_CYC = 16
) (
    input  logic                            ClkxCI,
    input  logic                            RstxSI,
    input  logic [31:0]                     SeedxDI,
    input  logic                            SeedValidxSI,
    output logic                            SeedReadyxSO,
    input  logic                            ReseedxSI,
    output logic [2*SHARES*(SHARES-1)-1:0]  ZxDO,
    output logic                            ValidxSO,
    input  logic                            ReadyxSI,
    output logic [15:0]                     WordCntxDO
);

    localparam int ZW  = 2 * SHARES * (SHARES - 1);
    localparam int NB  = LFSR_W / 32;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WCW = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;

    // Primitive trinomial/pentanomial taps for the supported state widths.
    localparam int TP1 = (LFSR_W == 32) ? 21 : (LFSR_W == 64) ? 62 : 125;
    localparam int TP2 = (LFSR_W == 32) ?  1 : (LFSR_W == 64) ? 60 : 100;
    localparam int TP3 = (LFSR_W == 32) ?  0 : (LFSR_W == 64) ? 59 :  98;
    localparam logic [LFSR_W-1:0] ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};
    localparam logic [LFSR_W-1:0] TAPS = (ONE << (LFSR_W-1)) | (ONE << TP1) | (ONE << TP2) | (ONE << TP3);

    if ((LFSR_W % 32) != 0 || LFSR_W < ZW || !(LFSR_W == 32 || LFSR_W == 64 || LFSR_W == 128)) begin : g_bad_width
        $error("dom_rand_gen: unsupported LFSR_W");
    end

    typedef enum logic [1:0] {SEED, WARM, RUN} state_t;

    state_t              state_q, state_nxt;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_nxt, lfsr_adv, seeded;
    logic [BCW-1:0]      beat_q, beat_nxt;
    logic [WCW-1:0]      warm_q, warm_nxt;
    logic [ZW-1:0]       z_q, z_nxt;
    logic                vld_q, vld_nxt;
    logic                srdy_q, srdy_nxt;
    logic [15:0]         cnt_q, cnt_nxt;

    function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < ZW; i++) begin
            r = {r[LFSR_W-2:0], ^(r & TAPS)};
        end
        return r;
    endfunction

    assign lfsr_adv = advance(lfsr_q);

    always_comb begin
        seeded = lfsr_q;
        seeded[32*int'(beat_q) +: 32] = SeedxDI;
    end

    always_comb begin
        state_nxt = state_q;
        lfsr_nxt  = lfsr_q;
        beat_nxt  = beat_q;
        warm_nxt  = warm_q;
        z_nxt     = z_q;
        vld_nxt   = vld_q;
        srdy_nxt  = srdy_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            SEED: begin
                if (SeedValidxSI && srdy_q) begin
                    lfsr_nxt = seeded;
                    beat_nxt = beat_q + BCW'(1);
                    if (beat_q == BCW'(NB - 1)) begin
                        // All-zero state would lock the LFSR up forever.
                        if (seeded == '0) lfsr_nxt = ONE;
                        state_nxt = WARM;
                        warm_nxt  = '0;
                        beat_nxt  = '0;
                        srdy_nxt  = 1'b0;
                    end
                end
            end
            WARM: begin
                lfsr_nxt = lfsr_adv;
                warm_nxt = warm_q + WCW'(1);
                if (warm_q == WCW'(WARMUP_CYC)) begin
                    state_nxt = RUN;
                    z_nxt     = lfsr_adv[ZW-1:0];
                    vld_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (vld_q && ReadyxSI) begin
                    lfsr_nxt = lfsr_adv;
                    z_nxt    = lfsr_adv[ZW-1:0];
                    cnt_nxt  = cnt_q + 16'd1;
                end
            end
            default: state_nxt = SEED;
        endcase
        // Reseed wins over the in-flight handshake's count, but the handshake itself still completes.
        if (ReseedxSI && (state_q == WARM || state_q == RUN)) begin
            state_nxt = SEED;
            vld_nxt   = 1'b0;
            beat_nxt  = '0;
            cnt_nxt   = '0;
            srdy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxSI) begin
            state_q <= SEED;
            lfsr_q  <= '0;
            beat_q  <= '0;
            warm_q  <= '0;
            z_q     <= '0;
            vld_q   <= 1'b0;
            srdy_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            lfsr_q  <= lfsr_nxt;
            beat_q  <= beat_nxt;
            warm_q  <= warm_nxt;
            z_q     <= z_nxt;
            vld_q   <= vld_nxt;
            srdy_q  <= srdy_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign ZxDO         = z_q;
    assign ValidxSO     = vld_q;
    assign SeedReadyxSO = srdy_q;
    assign WordCntxDO   = cnt_q;

endmodule

// File: tb/tb_dom_rand_gen.sv
// Scoreboard bench for dom_rand_gen: stimulus pushes model words per handshake, a negedge monitor pops and compares.
module tb_dom_rand_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed_dat;
    logic        seed_vld;
    logic        seed_rdy;
    logic        reseed;
    logic [23:0] z;
    logic        vld;
    logic        rdy;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    dom_rand_gen #(.SHARES(4), .LFSR_W(64), .WARMUP_CYC(16)) dut (
        .ClkxCI       (clk),
        .RstxSI       (rst),
        .SeedxDI      (seed_dat),
        .SeedValidxSI (seed_vld),
        .SeedReadyxSO (seed_rdy),
        .ReseedxSI    (reseed),
        .ZxDO         (z),
        .ValidxSO     (vld),
        .ReadyxSI     (rdy),
        .WordCntxDO   (cnt)
    );

    typedef struct packed {
        logic [23:0] z;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] mstate;
    logic [15:0] mcnt;
    logic [23:0] t1_first;

    // x^64+x^63+x^61+x^60+1, shift toward MSB, feedback into bit 0; 24 shifts per advance.
    function automatic logic [63:0] m_adv(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int i = 0; i < 24; i++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        seed_vld = 1'b0;
        seed_dat = '0;
        reseed   = 1'b0;
        rdy      = 1'b0;
        step();
        chk("rst_seed_rdy", seed_rdy, 1);
        chk("rst_valid", vld, 0);
        chk("rst_z", z, 0);
        chk("rst_cnt", cnt, 0);
        rst = 1'b0;
        sb_q.delete();
        mcnt = '0;
    endtask

    // Two beats, then check the WARMUP_CYC+1 latency and the first word against the model.
    task automatic seed2(input logic [31:0] lo, input logic [31:0] hi, input logic hold_reseed);
        int early;
        reseed   = hold_reseed;
        seed_vld = 1'b1;
        seed_dat = lo;
        step();
        chk("seed_rdy_mid", seed_rdy, 1);
        seed_dat = hi;
        step();
        seed_vld = 1'b0;
        reseed   = 1'b0;
        chk("seed_rdy_fall", seed_rdy, 0);
        early = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (vld !== 1'b0) early++;
        end
        chk("warm_valid_low", early, 0);
        step();
        chk("first_valid", vld, 1);
        mstate = {hi, lo};
        if (mstate == 64'd0) mstate = 64'd1;
        for (int i = 0; i < 17; i++) mstate = m_adv(mstate);
        mcnt = '0;
        chk("first_word", z, mstate[23:0]);
        chk("cnt_after_seed", cnt, 0);
    endtask

    task automatic take(input int n);
        rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({mstate[23:0], mcnt});
            mstate = m_adv(mstate);
            mcnt++;
            step();
        end
        rdy = 1'b0;
    endtask

    task automatic stall(input int n);
        rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("stall_z", z, mstate[23:0]);
            chk("stall_cnt", cnt, mcnt);
            chk("stall_valid", vld, 1);
        end
    endtask

    task automatic chk_reseeded(input string tag);
        chk({tag, "_valid"}, vld, 0);
        chk({tag, "_cnt"}, cnt, 0);
        chk({tag, "_seed_rdy"}, seed_rdy, 1);
        mcnt = '0;
    endtask

    // Monitor: every accepted word must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && vld === 1'b1 && rdy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_extra: unexpected word %h cnt %0d, expected none", z, cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_word", z, e.z);
                    chk("sb_cnt", cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs;
        rst = 1'b1; seed_vld = 1'b0; seed_dat = '0; reseed = 1'b0; rdy = 1'b0;
        mstate = '0; mcnt = '0;

        // Basic seed from state 1.
        do_reset();
        seed2(32'h1, 32'h0, 1'b0);
        t1_first = mstate[23:0];
        take(3);

        // All-zero seed forced to 1; reseed held during seeding must be ignored.
        do_reset();
        seed2(32'h0, 32'h0, 1'b1);
        chk("t2_same_first", z, t1_first);
        take(100);
        chk("t3_cnt", cnt, 100);
        stall(5);

        // Reseed together with a handshake.
        rdy    = 1'b1;
        reseed = 1'b1;
        sb_q.push_back({mstate[23:0], mcnt});
        mstate = m_adv(mstate);
        mcnt++;
        step();
        rdy    = 1'b0;
        reseed = 1'b0;
        chk_reseeded("t4");
        seed2(32'hDEADBEEF, 32'h01234567, 1'b0);
        take(20);
        stall(2);

        // Reseed while warming up.
        reseed = 1'b1;
        step();
        reseed = 1'b0;
        chk_reseeded("rs_run");
        seed_vld = 1'b1; seed_dat = 32'h5555AAAA; step();
        seed_dat = 32'h0F0F0F0F; step();
        seed_vld = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reseed = 1'b1;
        step();
        reseed = 1'b0;
        chk_reseeded("rs_warm");
        seed2(32'hCAFEF00D, 32'h00000001, 1'b0);
        take(5);

        // Reset after one beat: a full two-beat seed is needed again.
        reseed = 1'b1;
        step();
        reseed = 1'b0;
        seed_vld = 1'b1; seed_dat = 32'hAAAA0000; step();
        seed_vld = 1'b0;
        do_reset();
        seed2(32'h12345678, 32'h9ABCDEF0, 1'b0);
        take(5);

        // Reset mid-warmup.
        do_reset();
        seed_vld = 1'b1; seed_dat = 32'h11111111; step();
        seed_dat = 32'h22222222; step();
        seed_vld = 1'b0;
        for (int i = 0; i < 5; i++) step();
        do_reset();
        seed2(32'h0BADC0DE, 32'h76543210, 1'b0);
        take(5);

        // Random ready/reseed traffic.
        for (int c = 0; c < 3000; c++) begin
            rdy    = 1'($urandom_range(0, 1));
            rs     = ($urandom_range(0, 63) == 0);
            reseed = rs;
            if (rdy) begin
                sb_q.push_back({mstate[23:0], mcnt});
                mstate = m_adv(mstate);
                mcnt++;
            end
            step();
            rdy    = 1'b0;
            reseed = 1'b0;
            if (rs) begin
                chk_reseeded("rnd_reseed");
                seed2($urandom, $urandom, 1'b0);
            end else begin
                chk("rnd_z", z, mstate[23:0]);
                chk("rnd_cnt", cnt, mcnt);
            end
        end

        step();
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
